lsu_ctrl: RTL and testbench

- Load/store initiator between the core datapath and the byte-addressable data memory. It drives the memory's address, write-data, write-enable, size and sign/zero-extend inputs.
- Accepts one load or store request at a time over a valid/ready handshake.
- Aligned accesses go to memory as a single native access.
- Misaligned half/word accesses are split into sequential byte accesses. Load bytes are reassembled and then extended.
- Out-of-range or illegal-size requests get an error response and never touch memory.

---
 rtl/lsu_ctrl_pkg.sv | 38 +++
 rtl/lsu_extend.sv | 22 ++
 rtl/lsu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store initiator: bus width, access-size
// encodings (common with the data memory) and controller state encodings.
package lsu_ctrl_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        BYTE         = 2'b00,
        HALF_WORD    = 2'b01,
        WORD         = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            BYTE:      return 3'd1;
            HALF_WORD: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            BYTE:      return 1'b1;
            HALF_WORD: return ~addr_lo[0];
            WORD:      return (addr_lo == 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Zero/sign extension of a right-aligned value according to its access size;
// used on the byte-assembled result of split loads.
module lsu_extend #(
    parameter int BUS_WIDTH = 32
) (
    input  logic [1:0]           size,
    input  logic                 sext,
    input  logic [BUS_WIDTH-1:0] data,
    output logic [BUS_WIDTH-1:0] ext
);
    import lsu_ctrl_pkg::*;

    always_comb begin
        ext = data;
        case (size)
            BYTE:      ext = {{(BUS_WIDTH-8){sext & data[7]}}, data[7:0]};
            HALF_WORD: ext = {{(BUS_WIDTH-16){sext & data[15]}}, data[15:0]};
            default:   ext = data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, aligned accesses go out natively,
// misaligned half/word accesses are split into byte accesses and reassembled.
module lsu_ctrl #(
    parameter int BUS_WIDTH = lsu_ctrl_pkg::BUS_WIDTH,
    parameter int MEM_BYTES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_sext,
    output logic                 resp_valid,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    output logic                 mem_we,
    output logic [1:0]           mem_size,
    output logic                 mem_sz_ex,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);
    import lsu_ctrl_pkg::*;

    lsu_state_e           state_reg, state_next;
    logic                 we_reg, sext_reg, err_reg;
    logic [BUS_WIDTH-1:0] addr_reg, wdata_reg, rdata_reg;
    logic [1:0]           size_reg, k_reg;

    logic [2:0]           req_nbytes;
    logic [BUS_WIDTH:0]   req_last;
    logic                 req_err, req_aligned;
    logic [1:0]           last_k;
    logic                 split_last;
    logic [7:0]           split_byte;
    logic [BUS_WIDTH-1:0] asm_word, ext_word;

    // One extra bit on the end address keeps requests near the top of the
    // address space from wrapping back into the legal range.
    assign req_nbytes  = size_nbytes(req_size);
    assign req_last    = {1'b0, req_addr} + (BUS_WIDTH+1)'(req_nbytes - 3'd1);
    assign req_err     = (req_size == SIZE_ILLEGAL) || (req_last >= (BUS_WIDTH+1)'(MEM_BYTES));
    assign req_aligned = is_aligned(req_size, req_addr[1:0]);

    assign last_k     = (size_reg == HALF_WORD) ? 2'd1 : 2'd3;
    assign split_last = (k_reg == last_k);
    assign split_byte = wdata_reg[{k_reg, 3'b000} +: 8];

    // Assembly lanes; the lane being read this cycle bypasses its register so
    // the final byte is available to the extender in the last SPLIT cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       lane_hit;

            assign lane_hit = (state_reg == SPLIT) && (k_reg == 2'(gi));
            assign asm_word[8*gi +: 8] = lane_hit ? mem_rdata[7:0] : lane_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    lane_reg <= 8'h00;
                else if (lane_hit)
                    lane_reg <= mem_rdata[7:0];
            end
        end
        if (BUS_WIDTH > 32) begin : g_asm_pad
            assign asm_word[BUS_WIDTH-1:32] = '0;
        end
    endgenerate

    lsu_extend #(.BUS_WIDTH(BUS_WIDTH)) u_extend (
        .size (size_reg),
        .sext (sext_reg),
        .data (asm_word),
        .ext  (ext_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_aligned)
                        state_next = ACCESS;
                    else
                        state_next = SPLIT;
                end
            end
            ACCESS:  state_next = RESP;
            SPLIT:   state_next = split_last ? RESP : SPLIT;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_reg == IDLE);
        resp_valid = (state_reg == RESP);
        resp_rdata = (state_reg == RESP) ? rdata_reg : '0;
        resp_err   = (state_reg == RESP) && err_reg;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_size   = BYTE;
        mem_sz_ex  = 1'b0;
        case (state_reg)
            ACCESS: begin
                mem_addr  = addr_reg;
                mem_wdata = wdata_reg;
                mem_we    = we_reg;
                mem_size  = size_reg;
                mem_sz_ex = sext_reg;
            end
            SPLIT: begin
                mem_addr  = addr_reg + BUS_WIDTH'(k_reg);
                mem_wdata = {{(BUS_WIDTH-8){1'b0}}, split_byte};
                mem_we    = we_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            size_reg  <= BYTE;
            k_reg     <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        sext_reg  <= req_sext;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        size_reg  <= req_size;
                        err_reg   <= req_err;
                        rdata_reg <= '0;
                        k_reg     <= 2'd0;
                    end
                end
                ACCESS: rdata_reg <= we_reg ? '0 : mem_rdata;
                SPLIT: begin
                    k_reg <= k_reg + 2'd1;
                    if (split_last)
                        rdata_reg <= we_reg ? '0 : ext_word;
                end
                RESP: begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory environment plus a transaction-level
// reference model (byte array, size/alignment/range rules, latency rules).
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_sz_ex;
    logic [1:0]  mem_size;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] b0, b1, b2, b3;

    logic        tr_we    [$];
    logic [31:0] tr_addr  [$];
    logic [31:0] tr_wdata [$];
    logic [1:0]  tr_size  [$];

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_sext   (req_sext),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_sz_ex  (mem_sz_ex),
        .mem_rdata  (mem_rdata)
    );

    // Memory environment: little-endian byte array, combinational read
    always_comb begin
        b0 = mem[mem_addr[7:0]];
        b1 = mem[8'(mem_addr[7:0] + 8'd1)];
        b2 = mem[8'(mem_addr[7:0] + 8'd2)];
        b3 = mem[8'(mem_addr[7:0] + 8'd3)];
        case (mem_size)
            2'b00:   mem_rdata = {{24{mem_sz_ex & b0[7]}}, b0};
            2'b01:   mem_rdata = {{16{mem_sz_ex & b1[7]}}, b1, b0};
            default: mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]] = mem_wdata[7:0];
            if (mem_size != 2'b00)
                mem[8'(mem_addr[7:0] + 8'd1)] = mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                mem[8'(mem_addr[7:0] + 8'd2)] = mem_wdata[23:16];
                mem[8'(mem_addr[7:0] + 8'd3)] = mem_wdata[31:24];
            end
        end
    end

    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic sext,
                                  output logic exp_err, output logic [31:0] exp_rdata, output int exp_lat);
        int nb;
        longint last;
        logic [63:0] v;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        last = longint'(addr) + longint'(nb) - 1;
        exp_err = (size == 2'b11) || (last >= 256);
        exp_rdata = 32'h0;
        exp_lat = 1;
        if (exp_err) return;
        exp_lat = ((int'(addr[1:0]) % nb) == 0) ? 2 : nb + 1;
        if (we) begin
            for (int i = 0; i < nb; i++)
                ref_mem[8'(addr[7:0] + 8'(i))] = 8'(wdata >> (8 * i));
        end else begin
            v = 64'h0;
            for (int i = 0; i < nb; i++)
                v = v | (64'(ref_mem[8'(addr[7:0] + 8'(i))]) << (8 * i));
            if (sext && v[8*nb-1])
                v = v | ~((64'd1 << (8 * nb)) - 64'd1);
            exp_rdata = v[31:0];
        end
    endfunction

    // Issue one request, wait (bounded) for its response, record the memory bus trace.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sext, input bit hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int busy_ready);
        int w;
        tr_we.delete(); tr_addr.delete(); tr_wdata.delete(); tr_size.delete();
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_sext = sext;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        lat = 0; busy_ready = 0; rdata = 32'hxxxxxxxx; err = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (hold) begin
                req_addr = $urandom; req_wdata = $urandom;
                req_we = 1'($urandom); req_size = 2'($urandom); req_sext = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
            if (req_ready) busy_ready++;
            tr_we.push_back(mem_we); tr_addr.push_back(mem_addr);
            tr_wdata.push_back(mem_wdata); tr_size.push_back(mem_size);
        end
        $display("txn we=%0b addr=%h wdata=%h size=%0d sext=%0b -> rdata=%h err=%0b lat=%0d",
                 we, addr, wdata, size, sext, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_sext = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got %h/%b want 0/0", resp_rdata, resp_err); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_size !== 2'b00 || mem_sz_ex !== 1'b0) begin
            errors++; $display("FAIL reset_mem: got we=%b addr=%h wdata=%h size=%b sx=%b want all 0", mem_we, mem_addr, mem_wdata, mem_size, mem_sz_ex);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_aligned_word();
        logic [31:0] rd; logic er; int lat, br;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h00110113;
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h00110113;
        do_txn(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat, br);
        checks++; if (rd !== 32'h00110113 || er !== 1'b0) begin errors++; $display("FAIL aligned_word_data: got %h/%b want 00110113/0", rd, er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL aligned_word_latency: got %0d want 2", lat); end
        checks++; if (tr_size.size() != 1 || tr_size[0] !== 2'b10 || tr_we[0] !== 1'b0 || tr_addr[0] !== 32'h0) begin
            errors++; $display("FAIL aligned_word_bus: got %0d access(es) want one word read at 0", tr_size.size());
        end
    endtask

    task automatic test_byte_sext();
        logic [31:0] rd; logic er; int lat, br; logic ee; logic [31:0] er_d; int el;
        model(1'b1, 32'h20, 32'h000000F0, 2'b00, 1'b0, ee, er_d, el);
        do_txn(1'b1, 32'h20, 32'h000000F0, 2'b00, 1'b0, 1'b0, rd, er, lat, br);
        checks++; if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL store_byte: got %h/%b lat %0d want 0/0 lat 2", rd, er, lat); end
        do_txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b1, 1'b0, rd, er, lat, br);
        checks++; if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL load_byte_sext: got %h want FFFFFFF0", rd); end
        do_txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 1'b0, rd, er, lat, br);
        checks++; if (rd !== 32'h000000F0) begin errors++; $display("FAIL load_byte_zext: got %h want 000000F0", rd); end
    endtask

    task automatic test_split();
        logic [31:0] rd; logic er; int lat, br; logic ee; logic [31:0] er_d; int el;
        logic [31:0] wd;
        wd = 32'hAABBCCDD;
        model(1'b1, 32'h0D, wd, 2'b10, 1'b0, ee, er_d, el);
        do_txn(1'b1, 32'h0D, wd, 2'b10, 1'b0, 1'b0, rd, er, lat, br);
        checks++; if (lat !== 5 || er !== 1'b0) begin errors++; $display("FAIL split_store_latency: got %0d/%b want 5/0", lat, er); end
        checks++; if (tr_we.size() != 4) begin errors++; $display("FAIL split_store_cycles: got %0d want 4", tr_we.size()); end
        for (int i = 0; i < 4 && i < tr_we.size(); i++) begin
            checks++;
            if (tr_we[i] !== 1'b1 || tr_addr[i] !== 32'h0D + 32'(i) || tr_size[i] !== 2'b00 ||
                tr_wdata[i] !== {24'h0, wd[8*i +: 8]}) begin
                errors++; $display("FAIL split_store_beat%0d: got we=%b addr=%h wdata=%h size=%b want 1/%h/%h/00",
                                   i, tr_we[i], tr_addr[i], tr_wdata[i], tr_size[i], 32'h0D + 32'(i), {24'h0, wd[8*i +: 8]});
            end
        end
        do_txn(1'b0, 32'h0D, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat, br);
        checks++; if (rd !== 32'hAABBCCDD || lat !== 5) begin errors++; $display("FAIL split_load_word: got %h lat %0d want AABBCCDD lat 5", rd, lat); end
        do_txn(1'b0, 32'h0F, 32'h0, 2'b01, 1'b1, 1'b0, rd, er, lat, br);
        checks++; if (rd !== 32'hFFFFAABB || lat !== 3) begin errors++; $display("FAIL split_load_half: got %h lat %0d want FFFFAABB lat 3", rd, lat); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, br, nwe;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'hFD;       sizes[0] = 2'b10;
        addrs[1] = 32'h0;        sizes[1] = 2'b11;
        addrs[2] = 32'hFFFFFFFE; sizes[2] = 2'b01;
        for (int t = 0; t < 3; t++) begin
            do_txn(1'b1, addrs[t], 32'h12345678, sizes[t], 1'b0, 1'b0, rd, er, lat, br);
            nwe = 0;
            foreach (tr_we[i]) if (tr_we[i] === 1'b1) nwe++;
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nwe != 0) begin
                errors++; $display("FAIL error_resp%0d: got err=%b rdata=%h lat=%0d writes=%0d want 1/0/1/0", t, er, rd, lat, nwe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, br; logic ee; logic [31:0] erd; int el;
        model(1'b0, 32'h0D, 32'h0, 2'b10, 1'b0, ee, erd, el);
        do_txn(1'b0, 32'h0D, 32'h0, 2'b10, 1'b0, 1'b1, rd, er, lat, br);
        checks++; if (rd !== erd || lat !== el || br != 0) begin errors++; $display("FAIL hold_first: got %h lat %0d busy_ready %0d want %h lat %0d 0", rd, lat, br, erd, el); end
        model(1'b0, 32'h20, 32'h0, 2'b00, 1'b1, ee, erd, el);
        do_txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b1, 1'b1, rd, er, lat, br);
        checks++; if (rd !== erd || lat !== el || br != 0) begin errors++; $display("FAIL hold_second: got %h lat %0d busy_ready %0d want %h lat %0d 0", rd, lat, br, erd, el); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_after_resp: got ready %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid_split();
        logic [31:0] rd; logic er; int lat, br; logic ee; logic [31:0] erd; int el;
        bit saw_resp;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem[8'h41 + i] = 8'h55 + 8'(17 * i);
            ref_mem[8'h41 + i] = 8'h55 + 8'(17 * i);
        end
        req_we = 1'b1; req_addr = 32'h41; req_wdata = 32'h11223344; req_size = 2'b10; req_sext = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h41) begin errors++; $display("FAIL split_beat0: got we=%b addr=%h want 1/00000041", mem_we, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_size !== 2'b00 ||
            resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got we=%b addr=%h wdata=%h size=%b rv=%b rdy=%b want 0/0/0/00/0/1",
                               mem_we, mem_addr, mem_wdata, mem_size, resp_valid, req_ready);
        end
        saw_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        checks++; if (saw_resp || req_ready !== 1'b1) begin errors++; $display("FAIL reset_no_resp: got resp %b ready %b want 0/1", saw_resp, req_ready); end
        ref_mem[8'h41] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            model(1'b0, 32'h41 + 32'(i), 32'h0, 2'b00, 1'b0, ee, erd, el);
            do_txn(1'b0, 32'h41 + 32'(i), 32'h0, 2'b00, 1'b0, 1'b0, rd, er, lat, br);
            checks++; if (rd !== erd) begin errors++; $display("FAIL reset_partial_byte%0d: got %h want %h", i, rd, erd); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata; logic er, ee, we, sext; logic [1:0] size; int lat, br, el, nwe;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom); sext = 1'($urandom); size = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom_range(0, 259);
            wdata = $urandom;
            model(we, addr, wdata, size, sext, ee, erd, el);
            do_txn(we, addr, wdata, size, sext, 1'b0, rd, er, lat, br);
            nwe = 0;
            foreach (tr_we[i]) if (tr_we[i] === 1'b1) nwe++;
            checks++;
            if (rd !== erd || er !== ee || lat !== el || br != 0 || (ee && nwe != 0)) begin
                errors++; $display("FAIL random%0d: got rdata=%h err=%b lat=%0d busy_ready=%0d writes=%0d want %h/%b/%0d/0",
                                   n, rd, er, lat, br, nwe, erd, ee, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_byte_sext();
        test_split();
        test_errors();
        test_back_to_back();
        test_reset_mid_split();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
